// File: rtl/i2s_mic_pkg.sv
// Shared frame geometry, FSM encoding and slot decode helpers
// for the I2S microphone receiver.
package i2s_mic_pkg;

    localparam int frame_bits = 64;
    localparam int word_bits  = 24;

    typedef enum logic {
        STARTUP = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    // Slot positions 1..24 carry the sample, MSB first.
    function automatic logic is_data_bit(
        input logic [5:0] idx,
        input logic       ch
    );
        return (idx[5] == ch) &&
               (idx[4:0] >= 5'd1) &&
               (idx[4:0] <= 5'd24);
    endfunction

    function automatic logic is_last_bit(
        input logic [5:0] idx
    );
        return idx[4:0] == 5'd24;
    endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// I2S bit clock / word select generator: half-period divider plus
// a 64-position frame bit counter advanced on SCK falling edges.
module i2s_sck_gen #(
    parameter int unsigned sck_half_period = 5
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    output logic       o_sck,
    output logic       o_ws,
    output logic       o_rise,
    output logic       o_fall,
    output logic       o_frame_end,
    output logic [5:0] o_bit_idx
);

    localparam logic [7:0] HP_LAST = 8'(sck_half_period - 1);

    logic [7:0] r_hcnt;
    logic       r_sck;
    logic [5:0] r_bit;
    logic       w_wrap;

    assign w_wrap = (r_hcnt == HP_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hcnt <= 8'd0;
            r_sck  <= 1'b0;
            r_bit  <= 6'd0;
        end else if (w_wrap) begin
            r_hcnt <= 8'd0;
            r_sck  <= ~r_sck;
            if (r_sck) begin
                r_bit <= r_bit + 6'd1;
            end
        end else begin
            r_hcnt <= r_hcnt + 8'd1;
        end
    end

    // Strobes mark the last clk cycle before the SCK edge they name.
    assign o_rise      = w_wrap & ~r_sck;
    assign o_fall      = w_wrap & r_sck;
    assign o_frame_end = o_fall & (r_bit == 6'd63);
    assign o_sck       = r_sck;
    assign o_ws        = r_bit[5];
    assign o_bit_idx   = r_bit;

endmodule

// File: rtl/i2s_mic_sample_receiver.sv
// I2S MEMS microphone receiver: runs SCK/WS, discards a warm-up period,
// then captures one 24-bit sample per frame from the selected slot.
module i2s_mic_sample_receiver
    import i2s_mic_pkg::*;
#(
    parameter int unsigned clk_mhz         = 27,
    parameter int unsigned sck_half_period = 5,
    parameter int unsigned startup_frames  = 4096,
    parameter int unsigned channel         = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 lr,
    output logic                 ws,
    output logic                 sck,
    input  logic                 sd,
    output logic [word_bits-1:0] value,
    output logic                 value_valid
);

    localparam logic CH = channel[0];
    localparam int FCW = (startup_frames < 2) ? 1 : $clog2(startup_frames);
    localparam int unsigned LAST_FRAME =
        (startup_frames == 0) ? 0 : startup_frames - 1;

    if (clk_mhz == 0 || sck_half_period < 3 ||
        sck_half_period > 255 || channel > 1) begin : g_bad_param
        $error("i2s_mic_sample_receiver: illegal parameter value");
    end

    logic                 w_rise;
    logic                 w_fall;
    logic                 w_frame_end;
    logic [5:0]           w_bit_idx;
    logic                 w_startup_done;
    logic [word_bits-1:0] w_shift_next;

    state_t               r_state;
    logic [FCW-1:0]       r_frames;
    logic                 r_armed;
    logic                 r_sd_meta;
    logic                 r_sd_sync;
    logic [word_bits-1:0] r_shift;
    logic [word_bits-1:0] r_value;
    logic                 r_valid;

    i2s_sck_gen #(
        .sck_half_period(sck_half_period)
    ) u_sck_gen (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .o_sck       (sck),
        .o_ws        (ws),
        .o_rise      (w_rise),
        .o_fall      (w_fall),
        .o_frame_end (w_frame_end),
        .o_bit_idx   (w_bit_idx)
    );

    assign w_startup_done = (r_frames == FCW'(LAST_FRAME));
    assign w_shift_next   = {r_shift[word_bits-2:0], r_sd_sync};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= STARTUP;
            r_frames  <= '0;
            r_armed   <= 1'b0;
            r_sd_meta <= 1'b0;
            r_sd_sync <= 1'b0;
            r_shift   <= '0;
            r_value   <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_sd_meta <= sd;
            r_sd_sync <= r_sd_meta;
            r_valid   <= 1'b0;
            unique case (r_state)
                STARTUP: begin
                    if (w_frame_end) begin
                        if (w_startup_done) begin
                            r_state <= CAPTURE;
                        end else begin
                            r_frames <= r_frames + FCW'(1);
                        end
                    end
                end
                CAPTURE: begin
                    // Arm on the first SCK rise of a fresh frame.
                    if (w_rise && w_bit_idx == 6'd0) begin
                        r_armed <= 1'b1;
                    end
                    if (r_armed && w_fall && is_data_bit(w_bit_idx, CH)) begin
                        r_shift <= w_shift_next;
                        if (is_last_bit(w_bit_idx)) begin
                            r_value <= w_shift_next;
                            r_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= STARTUP;
                end
            endcase
        end
    end

    assign lr          = CH;
    assign value       = r_value;
    assign value_valid = r_valid;

endmodule

// File: tb/tb_i2s_mic_sample_receiver.sv
// Directed bench: two receivers (left/slow, right/fast) fed by
// behavioural I2S microphone models.
module tb_i2s_mic_sample_receiver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst0_n = 1'b0;
    logic        sd0    = 1'b0;
    logic        lr0, ws0, sck0, vv0;
    logic [23:0] val0;

    logic        rst1_n = 1'b0;
    logic        sd1    = 1'b0;
    logic        lr1, ws1, sck1, vv1;
    logic [23:0] val1;

    i2s_mic_sample_receiver #(
        .clk_mhz(27), .sck_half_period(5),
        .startup_frames(2), .channel(0)
    ) u_dut0 (
        .clk(clk), .rst_n(rst0_n), .lr(lr0), .ws(ws0), .sck(sck0),
        .sd(sd0), .value(val0), .value_valid(vv0)
    );

    i2s_mic_sample_receiver #(
        .clk_mhz(27), .sck_half_period(3),
        .startup_frames(1), .channel(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst1_n), .lr(lr1), .ws(ws1), .sck(sck1),
        .sd(sd1), .value(val1), .value_valid(vv1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic mic_bit(input int b, input logic [23:0] l,
                                     input logic [23:0] r);
        int p;
        logic [23:0] w;
        p = b % 32;
        w = (b >= 32) ? r : l;
        if (p >= 1 && p <= 24) return w[5'(24 - p)];
        return 1'($urandom_range(0, 1));
    endfunction

    // Microphone models: words latched at frame start, sd driven
    // one clk after each SCK fall.
    logic [23:0] nl0 = '0, nr0 = '0, cl0 = '0, cr0 = '0;
    logic [23:0] nl1 = '0, nr1 = '0, cl1 = '0, cr1 = '0;
    int   b0 = 0, b1 = 0;

    always begin : m_mic0
        logic rs, ps, pend;
        @(posedge clk);
        rs = rst0_n;
        #1;
        if (!rs) begin
            b0 = 0; ps = 0; pend = 0; sd0 = 0;
            cl0 = nl0; cr0 = nr0;
        end else begin
            sd0 = pend;
            if (ps && !sck0) begin
                b0 = (b0 + 1) % 64;
                if (b0 == 0) begin cl0 = nl0; cr0 = nr0; end
            end
            ps = sck0;
            pend = mic_bit(b0, cl0, cr0);
        end
    end

    always begin : m_mic1
        logic rs, ps, pend;
        @(posedge clk);
        rs = rst1_n;
        #1;
        if (!rs) begin
            b1 = 0; ps = 0; pend = 0; sd1 = 0;
            cl1 = nl1; cr1 = nr1;
        end else begin
            sd1 = pend;
            if (ps && !sck1) begin
                b1 = (b1 + 1) % 64;
                if (b1 == 0) begin cl1 = nl1; cr1 = nr1; end
            end
            ps = sck1;
            pend = mic_bit(b1, cl1, cr1);
        end
    end

    int sck_min = 99999, sck_max = 0, ws_min = 99999, ws_max = 0;
    int ws_bad = 0, vdbl0 = 0, vdbl1 = 0;

    always begin : m_timing
        logic rs, ps, pw, hs, hw, pv0, pv1;
        int ls, lw;
        @(posedge clk);
        rs = rst0_n;
        #1;
        if (!rs) begin
            ps = 0; pw = 0; hs = 0; hw = 0;
        end else begin
            if (!ps && sck0) begin
                if (hs) begin
                    if (cyc - ls < sck_min) sck_min = cyc - ls;
                    if (cyc - ls > sck_max) sck_max = cyc - ls;
                end
                ls = cyc; hs = 1;
            end
            if (!pw && ws0) begin
                if (hw) begin
                    if (cyc - lw < ws_min) ws_min = cyc - lw;
                    if (cyc - lw > ws_max) ws_max = cyc - lw;
                end
                lw = cyc; hw = 1;
            end
            if (ws0 != pw && !(ps && !sck0)) ws_bad++;
            ps = sck0; pw = ws0;
        end
        if (vv0 && pv0) vdbl0++;
        if (vv1 && pv1) vdbl1++;
        pv0 = vv0; pv1 = vv1;
    end

    typedef struct {
        logic [23:0] left;
        logic [23:0] right;
        logic [23:0] exp;
    } vec_t;

    vec_t tbl0[6];

    task automatic wait_v0(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(posedge clk); #1; n++;
            if (vv0) break;
        end
    endtask

    task automatic wait_v1(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(posedge clk); #1; n++;
            if (vv1) break;
        end
    endtask

    task automatic run0();
        int n, np, last;
        rst0_n = 0;
        nl0 = tbl0[0].left; nr0 = tbl0[0].right;
        repeat (3) @(posedge clk);
        #1;
        chk("rst0_sck", 32'(sck0), 0);
        chk("rst0_ws", 32'(ws0), 0);
        chk("rst0_value", 32'(val0), 0);
        chk("rst0_valid", 32'(vv0), 0);
        chk("rst0_lr", 32'(lr0), 0);
        rst0_n = 1;
        np = 0;
        repeat (1280) begin @(posedge clk); #1; if (vv0) np++; end
        chk("startup0_nopulse", 32'(np), 0);
        chk("startup0_value", 32'(val0), 0);
        wait_v0(700, n);
        chk("first0_frame", 32'((1280 + n) / 640), 2);
        chk("vec0_0", 32'(val0), 32'(tbl0[0].exp));
        last = cyc;
        for (int i = 1; i < 6; i++) begin
            nl0 = tbl0[i].left; nr0 = tbl0[i].right;
            wait_v0(700, n);
            chk($sformatf("vec0_%0d_pulse", i), 32'(vv0), 1);
            chk($sformatf("vec0_%0d", i), 32'(val0), 32'(tbl0[i].exp));
            chk($sformatf("vec0_%0d_interval", i), 32'(cyc - last), 640);
            last = cyc;
        end
        nl0 = 24'h5A5A5A; nr0 = 24'hFFFFFF;
        n = 0;
        while (b0 != 10 && n < 700) begin @(posedge clk); #1; n++; end
        chk("midrst_reach_bit10", 32'(b0), 10);
        rst0_n = 0;
        @(posedge clk); #1;
        rst0_n = 1;
        chk("midrst_sck", 32'(sck0), 0);
        chk("midrst_ws", 32'(ws0), 0);
        chk("midrst_value", 32'(val0), 0);
        chk("midrst_valid", 32'(vv0), 0);
        np = 0;
        repeat (1280) begin @(posedge clk); #1; if (vv0) np++; end
        chk("midrst_nopulse", 32'(np), 0);
        wait_v0(700, n);
        chk("midrst_frame", 32'((1280 + n) / 640), 2);
        chk("midrst_value_after", 32'(val0), 32'h5A5A5A);
    endtask

    task automatic run1();
        int n, last;
        logic [23:0] exp;
        rst1_n = 0;
        nl1 = 24'($urandom); nr1 = 24'h123456;
        repeat (3) @(posedge clk);
        #1;
        chk("rst1_lr", 32'(lr1), 1);
        chk("rst1_sck", 32'(sck1), 0);
        chk("rst1_ws", 32'(ws1), 0);
        chk("rst1_value", 32'(val1), 0);
        chk("rst1_valid", 32'(vv1), 0);
        rst1_n = 1;
        wait_v1(1200, n);
        chk("first1_frame", 32'(n / 384), 1);
        chk("right_123456", 32'(val1), 32'h123456);
        last = cyc;
        for (int i = 0; i < 8; i++) begin
            nl1 = 24'($urandom); nr1 = 24'($urandom);
            exp = nr1;
            wait_v1(500, n);
            chk($sformatf("rand1_%0d_pulse", i), 32'(vv1), 1);
            chk($sformatf("rand1_%0d", i), 32'(val1), 32'(exp));
            chk($sformatf("rand1_%0d_interval", i), 32'(cyc - last), 384);
            last = cyc;
        end
    endtask

    initial begin
        tbl0[0] = '{24'h800001, 24'hFFFFFF, 24'h800001};
        tbl0[1] = '{24'h7FFFFF, 24'h000000, 24'h7FFFFF};
        tbl0[2] = '{24'h000000, 24'hFFFFFF, 24'h000000};
        tbl0[3] = '{24'hC3A5F0, 24'h123456, 24'hC3A5F0};
        tbl0[4] = '{24'h000001, 24'h800000, 24'h000001};
        tbl0[5] = '{24'hFEDCBA, 24'h555555, 24'hFEDCBA};
        fork
            run0();
            run1();
        join
        chk("sck_period_min", 32'(sck_min), 10);
        chk("sck_period_max", 32'(sck_max), 10);
        chk("ws_period_min", 32'(ws_min), 640);
        chk("ws_period_max", 32'(ws_max), 640);
        chk("ws_off_fall_edge", 32'(ws_bad), 0);
        chk("valid0_width", 32'(vdbl0), 0);
        chk("valid1_width", 32'(vdbl1), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: timeout after %0d cycles", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i2s_mic_sample_receiver.md
I2S_MIC_SAMPLE_RECEIVER -- requirements
Module: i2s_mic_sample_receiver

Interface
REQ-001 SHALL have parameter clk_mhz, default 27, system clock frequency in MHz (documentation only; not used in arithmetic).
REQ-002 SHALL have parameter sck_half_period, default 5, clk cycles per SCK half-period; legal range 3..255.
REQ-003 SHALL have parameter startup_frames, default 4096, number of frames discarded after reset.
REQ-004 SHALL have parameter channel, default 0, selected slot (0 = left, WS low; 1 = right, WS high).
REQ-005 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset; there SHALL be one clock, and reset SHALL be synchronous and active-low.
REQ-007 SHALL have port lr  output  1  microphone channel strap, constant equal to channel.
REQ-008 SHALL have port ws  output  1  I2S word select.
REQ-009 SHALL have port sck  output  1  I2S bit clock.
REQ-010 SHALL have port sd  input  1  microphone serial data, asynchronous to clk.
REQ-011 SHALL have port value  output  24  last captured two's-complement sample.
REQ-012 SHALL have port value_valid  output  1  one-cycle pulse marking an update of value.

Function
REQ-013 SHALL pass sd through a two-flop synchronizer before any use.
REQ-014 SHALL divide clk with a half-period counter 0..sck_half_period-1; sck SHALL toggle when the counter wraps, giving period 2*sck_half_period clk cycles (default 10 -> 2.7 MHz).
REQ-015 SHALL keep a 6-bit frame bit counter advanced on each sck falling edge, wrapping 63 -> 0 (64 SCK per frame).
REQ-016 SHALL drive ws as bit 5 of the bit counter, so ws changes on sck falling edges (ws low for bits 0..31, high for bits 32..63).
REQ-017 SHALL sample synchronized sd on the last clk cycle of each sck high phase.
REQ-018 SHALL treat slot bit positions 1..24 (counter values channel*32+1 .. channel*32+24) as data, MSB first; all other positions SHALL be ignored.
REQ-019 SHALL shift sampled data bits into a 24-bit shift register; all other bits SHALL leave it unchanged.
REQ-020 SHALL, in the clk cycle after the 24th data bit is sampled, load value from the shift register and assert value_valid for exactly one cycle (one pulse per frame).
REQ-021 SHALL use state STARTUP after reset; sck and ws SHALL run; value and value_valid SHALL stay 0.
REQ-022 SHALL count completed frames (bit counter 63 -> 0) in STARTUP and move to CAPTURE when the count reaches startup_frames.
REQ-023 SHALL start capture at the next frame boundary after the move to CAPTURE; a partial frame SHALL never produce value_valid.
REQ-024 SHALL stay in CAPTURE until reset; there is no other exit.
REQ-025 SHALL produce exactly one value update per 64*2*sck_half_period clk cycles in CAPTURE.

Reset
REQ-026 SHALL, while rst_n is low at a clk edge, clear sck, ws, value, value_valid, all counters, the shift register and the synchronizer, and SHALL set state to STARTUP.
REQ-027 SHALL, on reset asserted mid-frame, discard the partial word; the first cycle after rst_n is released SHALL see sck=0, ws=0, value_valid=0.

Structure
REQ-028 SHALL place frame_bits=64, word_bits=24 and the state enum (STARTUP, CAPTURE) in shared package i2s_mic_pkg.
REQ-029 SHALL instantiate one sub-module, i2s_sck_gen, holding the half-period counter and bit counter and emitting sck, ws, rise/fall strobes and the bit index; capture and the FSM SHALL stay in the top.

Verification
REQ-030 SHALL cover SCK timing: default parameters -> sck period 10 clk; ws period 640 clk; ws toggles only on sck falling edges.
REQ-031 SHALL cover startup: startup_frames=2 -> no value_valid in the first 1280 clk after reset; first pulse in the third frame.
REQ-032 SHALL cover capture: left slot model drives 24'h800001 -> value=24'h800001 with one value_valid pulse; right slot data 24'hFFFFFF is ignored.
REQ-033 SHALL cover right-channel selection: channel=1, lr=1, right slot 24'h123456 -> value=24'h123456.
REQ-034 SHALL cover mid-frame reset: rst_n low for 1 cycle at bit 10 -> all outputs 0 next cycle; no pulse until startup_frames elapse again.
REQ-035 SHALL cover the minimum divider: sck_half_period=3 with sd changing 1 clk after the sck falling edge -> all bits captured correctly over 8 frames of random data.
